dclk_monitor: RTL and testbench

Receive-side companion of the activity/rate-controlled divided-clock FSM: it watches the `dclk` pulse stream that FSM produces and recovers the pulse period, the fast/slow rate class and the activity status from it. Each measured period is delivered through a valid/ready output register for downstream consumers. The block runs in the same clock domain as the generator, so `dclk` needs no synchronizer.

---
 rtl/dclk_monitor.sv | 122 ++++++++++++
 tb/tb_dclk_monitor.sv | 253 +++++++++++++++++++++++++
 2 files changed

// File: rtl/dclk_monitor.sv
// dclk_monitor
//   Receive-side companion of the divided-clock generator. It watches the
//   dclk pulse stream in the clk domain and recovers three things from it:
//   the pulse period, whether that period is fast or slow, and whether the
//   stream is active at all. Each measured period is offered through a
//   valid/ready output register.
//
// Parameters
//   CW        width of the interval counter and of period
//   FAST_MAX  periods <= FAST_MAX clk cycles are classified fast
//   TIMEOUT   clk cycles without a dclk rise before the stream counts as
//             inactive (2 <= TIMEOUT <= 2**CW-1)
//
// Ports
//   clk      in   system clock, all logic on posedge
//   rst_b    in   asynchronous active-low reset
//   dclk     in   pulse stream, synchronous to clk
//   per_rdy  in   consumer ready for period
//   period   out  clk cycles between the last two accepted dclk rises
//   per_vld  out  period/fast hold a measurement not yet taken
//   fast     out  rate class of the value in period
//   act      out  pulse stream is live
//   ovf      out  sticky: a measurement was dropped due to backpressure
module dclk_monitor #(
  parameter int unsigned CW       = 8,
  parameter int unsigned FAST_MAX = 3,
  parameter int unsigned TIMEOUT  = 20
) (
  input  logic          clk,
  input  logic          rst_b,
  input  logic          dclk,
  input  logic          per_rdy,
  output logic [CW-1:0] period,
  output logic          per_vld,
  output logic          fast,
  output logic          act,
  output logic          ovf
);

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  state_t        state;
  state_t        state_nxt;
  logic          dclk_q;
  logic          rise;
  logic [CW-1:0] cnt;
  logic [CW-1:0] cnt_nxt;
  logic          capture;
  logic          take;

  assign rise = dclk & ~dclk_q;
  assign take = per_vld & per_rdy;
  assign act  = (state == RUN);

  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      state  <= IDLE;
      dclk_q <= 1'b0;
      cnt    <= '0;
    end else begin
      state  <= state_nxt;
      dclk_q <= dclk;
      cnt    <= cnt_nxt;
    end
  end

  // cnt holds the number of edges since the last rise, so at the next rise
  // it already equals the period. A rise coinciding with cnt == TIMEOUT is
  // still a valid measurement; only the absence of a rise times out.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    capture   = 1'b0;
    unique case (state)
      IDLE: begin
        if (rise) begin
          state_nxt = RUN;
          cnt_nxt   = CW'(1);
        end
      end
      RUN: begin
        if (rise) begin
          capture = 1'b1;
          cnt_nxt = CW'(1);
        end else if (cnt == CW'(TIMEOUT)) begin
          state_nxt = IDLE;
        end else begin
          cnt_nxt = cnt + CW'(1);
        end
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  // Output register: a new capture may replace the held value only when the
  // register is empty or being drained in the same cycle; otherwise it is
  // dropped and recorded in the sticky ovf flag.
  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      period  <= '0;
      per_vld <= 1'b0;
      fast    <= 1'b0;
      ovf     <= 1'b0;
    end else if (capture) begin
      if (!per_vld || per_rdy) begin
        period  <= cnt;
        fast    <= (cnt <= CW'(FAST_MAX));
        per_vld <= 1'b1;
      end else begin
        ovf <= 1'b1;
      end
    end else if (take) begin
      per_vld <= 1'b0;
    end
  end

endmodule

// File: tb/tb_dclk_monitor.sv
// tb_dclk_monitor
//   Directed bench for dclk_monitor (CW=8, FAST_MAX=3, TIMEOUT=20). A
//   behavioural model records the edge number of each dclk rise and derives
//   period, rate class, activity and output-register state arithmetically;
//   a compare process checks every DUT output against it after each clk
//   edge, and literal checks pin key values of each scenario.
module tb_dclk_monitor;

  localparam int unsigned CW       = 8;
  localparam int unsigned FAST_MAX = 3;
  localparam int unsigned TIMEOUT  = 20;

  logic          clk;
  logic          rst_b;
  logic          dclk;
  logic          per_rdy;
  logic [CW-1:0] period;
  logic          per_vld;
  logic          fast;
  logic          act;
  logic          ovf;

  int total;
  int bad;

  // model state
  int k;
  int m_last;
  bit m_prev;
  bit m_act;
  bit m_vld;
  bit m_fast;
  bit m_ovf;
  int m_per;

  dclk_monitor #(
    .CW      (CW),
    .FAST_MAX(FAST_MAX),
    .TIMEOUT (TIMEOUT)
  ) dut (
    .clk    (clk),
    .rst_b  (rst_b),
    .dclk   (dclk),
    .per_rdy(per_rdy),
    .period (period),
    .per_vld(per_vld),
    .fast   (fast),
    .act    (act),
    .ovf    (ovf)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_prev = 1'b0;
    m_act  = 1'b0;
    m_last = 0;
    m_vld  = 1'b0;
    m_fast = 1'b0;
    m_ovf  = 1'b0;
    m_per  = 0;
  endtask

  // Advance the model by one clk edge using the inputs about to be sampled.
  task automatic model_edge();
    bit is_rise;
    bit have;
    int meas;
    k++;
    is_rise = dclk && !m_prev;
    m_prev  = dclk;
    have    = 1'b0;
    meas    = 0;
    if (is_rise) begin
      if (m_act) begin
        have = 1'b1;
        meas = k - m_last;
      end
      m_act  = 1'b1;
      m_last = k;
    end else if (m_act && (k - m_last) >= int'(TIMEOUT)) begin
      m_act = 1'b0;
    end
    if (have) begin
      if (!m_vld || per_rdy) begin
        m_per  = meas;
        m_fast = (meas <= int'(FAST_MAX));
        m_vld  = 1'b1;
      end else begin
        m_ovf = 1'b1;
      end
    end else if (m_vld && per_rdy) begin
      m_vld = 1'b0;
    end
  endtask

  // Called at a negedge: drive inputs, advance the model, wait one cycle.
  task automatic step(input logic d, input logic r);
    dclk    = d;
    per_rdy = r;
    model_edge();
    @(negedge clk);
  endtask

  task automatic idle(input int n, input logic r);
    for (int i = 0; i < n; i++) step(1'b0, r);
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, ".period"}, period, 0);
    chk({tag, ".per_vld"}, per_vld, 0);
    chk({tag, ".fast"}, fast, 0);
    chk({tag, ".act"}, act, 0);
    chk({tag, ".ovf"}, ovf, 0);
  endtask

  // Compare process: every edge, 1 time unit after it.
  always @(posedge clk) begin
    #1;
    chk("cmp.period", period, m_per[CW-1:0]);
    chk("cmp.per_vld", per_vld, m_vld);
    chk("cmp.fast", fast, m_fast);
    chk("cmp.act", act, m_act);
    chk("cmp.ovf", ovf, m_ovf);
  end

  initial begin
    total   = 0;
    bad     = 0;
    k       = 0;
    rst_b   = 1'b0;
    dclk    = 1'b0;
    per_rdy = 1'b0;
    model_reset();
    #1;
    chk_zero("rst0");
    @(negedge clk);
    @(negedge clk);
    rst_b = 1'b1;
    idle(3, 1'b0);
    chk_zero("rst_hold");

    // fast stream: period 3, 1-cycle pulses
    for (int i = 0; i < 4; i++) begin
      step(1'b1, 1'b1);
      if (i == 0) begin
        chk("fast.first_act", act, 1);
        chk("fast.first_vld", per_vld, 0);
      end else begin
        chk("fast.vld", per_vld, 1);
        chk("fast.period", period, 3);
        chk("fast.fast", fast, 1);
      end
      idle(2, 1'b1);
      chk("fast.vld_drop", per_vld, 0);
    end

    // slow stream: period 10, high time 4
    for (int i = 0; i < 3; i++) begin
      step(1'b1, 1'b1);
      if (i > 0) begin
        chk("slow.period", period, 10);
        chk("slow.fast", fast, 0);
        chk("slow.vld", per_vld, 1);
      end
      step(1'b1, 1'b1);
      chk("slow.one_meas", per_vld, 0);
      step(1'b1, 1'b1);
      step(1'b1, 1'b1);
      idle(6, 1'b1);
    end

    // backpressure: period 5
    step(1'b1, 1'b1);
    idle(4, 1'b1);
    step(1'b1, 1'b0);
    chk("bp.first_period", period, 5);
    idle(4, 1'b0);
    step(1'b1, 1'b0);
    chk("bp.held_period", period, 5);
    chk("bp.ovf", ovf, 1);
    chk("bp.vld", per_vld, 1);
    step(1'b0, 1'b0);
    step(1'b0, 1'b1);
    chk("bp.drain_vld", per_vld, 0);
    chk("bp.drain_period", period, 5);
    idle(2, 1'b0);
    step(1'b1, 1'b0);
    idle(5, 1'b0);
    step(1'b1, 1'b1);
    chk("bp.simul_period", period, 6);
    chk("bp.simul_vld", per_vld, 1);
    chk("bp.simul_ovf", ovf, 1);

    // timeout after the rise just above
    idle(19, 1'b1);
    chk("to.act_hold", act, 1);
    step(1'b0, 1'b1);
    chk("to.act_drop", act, 0);
    idle(3, 1'b1);
    step(1'b1, 1'b1);
    chk("to.rearm_act", act, 1);
    chk("to.rearm_vld", per_vld, 0);
    idle(6, 1'b1);
    step(1'b1, 1'b1);
    chk("to.period7", period, 7);
    chk("to.vld7", per_vld, 1);

    // boundary: exactly TIMEOUT, then TIMEOUT+1
    idle(19, 1'b1);
    step(1'b1, 1'b1);
    chk("bnd.period20", period, 20);
    chk("bnd.act20", act, 1);
    chk("bnd.vld20", per_vld, 1);
    idle(20, 1'b1);
    chk("bnd.act21_drop", act, 0);
    step(1'b1, 1'b1);
    chk("bnd.vld21", per_vld, 0);
    chk("bnd.period21", period, 20);
    chk("bnd.act21_rearm", act, 1);

    // reset mid-RUN with a measurement pending
    idle(3, 1'b0);
    step(1'b1, 1'b0);
    chk("mid.vld", per_vld, 1);
    chk("mid.period", period, 4);
    chk("mid.ovf", ovf, 1);
    #2;
    rst_b = 1'b0;
    model_reset();
    #1;
    chk_zero("mid_rst");
    @(negedge clk);
    rst_b = 1'b1;
    idle(3, 1'b0);
    chk_zero("mid_hold");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
